battleship_game_ctrl: RTL and testbench

- Game-logic stage between the debounced button signals and the display stages.
- Owns both game boards, both ship counters and the player turn; the VGA and SSD stages only read them.
- Runs a cursor, handles ship placement for both players, then alternating shots, hit/miss resolution and game-over detection.
- All outputs are registered and held stable between updates.

---
 rtl/battleship_game_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_battleship_game_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/battleship_game_ctrl.sv
// Battleship game-logic stage: cursor, placement, shots and scoring.
// Owns both boards, both ship counters and the turn bit.
module battleship_game_ctrl #(
    parameter int GRID_W     = 5,
    parameter int GRID_H     = 5,
    parameter int NUM_SHIPS  = 5,
    parameter int BOARD_SIZE = 3*GRID_W*GRID_H
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  btn_c,
    input  logic                  btn_l,
    input  logic                  btn_r,
    input  logic                  btn_u,
    input  logic                  btn_d,
    output logic [BOARD_SIZE-1:0] p1_board,
    output logic [BOARD_SIZE-1:0] p2_board,
    output logic [2:0]            p1_ships,
    output logic [2:0]            p2_ships,
    output logic                  turn,
    output logic [2:0]            cursor_x,
    output logic [2:0]            cursor_y,
    output logic [2:0]            phase,
    output logic                  winner
);

    typedef enum logic [2:0] {
        PLACE_P1  = 3'd0,
        PLACE_P2  = 3'd1,
        FIRE      = 3'd2,
        RESOLVE   = 3'd3,
        GAME_OVER = 3'd4
    } phase_t;

    localparam logic [2:0] EMPTY = 3'd0;
    localparam logic [2:0] SHIP  = 3'd1;
    localparam logic [2:0] MISS  = 3'd2;
    localparam logic [2:0] HIT   = 3'd3;
    localparam logic [2:0] X_MAX = 3'(GRID_W-1);
    localparam logic [2:0] Y_MAX = 3'(GRID_H-1);
    localparam logic [2:0] SHIPS = 3'(NUM_SHIPS);

    phase_t                state, state_nxt;
    logic [BOARD_SIZE-1:0] p1_nxt, p2_nxt;
    logic [2:0]            p1s_nxt, p2s_nxt;
    logic                  turn_nxt, win_nxt;
    logic [2:0]            cx_nxt, cy_nxt;
    logic [2:0]            cnt, cnt_nxt;
    logic [6:0]            tgt, tgt_nxt;
    logic [6:0]            cur_idx;
    logic [4:0]            btn_q, btn_prev, press;
    logic                  move_en;
    logic [2:0]            own_cell, opp_cell, res_cell;
    logic [2:0]            ships_left, ships_dec;

    function automatic logic [2:0] cell_at(
        input logic [BOARD_SIZE-1:0] b,
        input logic [6:0]            i
    );
        return b[3*i +: 3];
    endfunction

    // {c,u,d,l,r}: a press is a sampled level not present the cycle before
    assign press   = btn_q & ~btn_prev;
    assign cur_idx = 7'(cursor_y) * 7'(GRID_W) + 7'(cursor_x);
    assign phase   = state;

    assign own_cell   = cell_at(turn ? p2_board : p1_board, cur_idx);
    assign opp_cell   = cell_at(turn ? p1_board : p2_board, cur_idx);
    assign res_cell   = cell_at(turn ? p1_board : p2_board, tgt);
    assign ships_left = turn ? p1_ships : p2_ships;
    assign ships_dec  = (ships_left != 3'd0) ? ships_left - 3'd1 : 3'd0;

    // State register; reset wins over any pending update
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= PLACE_P1;
            p1_board <= '0;
            p2_board <= '0;
            p1_ships <= SHIPS;
            p2_ships <= SHIPS;
            turn     <= 1'b0;
            cursor_x <= 3'd0;
            cursor_y <= 3'd0;
            winner   <= 1'b0;
            cnt      <= 3'd0;
            tgt      <= 7'd0;
            btn_q    <= '1;
            btn_prev <= '1;
        end else begin
            state    <= state_nxt;
            p1_board <= p1_nxt;
            p2_board <= p2_nxt;
            p1_ships <= p1s_nxt;
            p2_ships <= p2s_nxt;
            turn     <= turn_nxt;
            cursor_x <= cx_nxt;
            cursor_y <= cy_nxt;
            winner   <= win_nxt;
            cnt      <= cnt_nxt;
            tgt      <= tgt_nxt;
            btn_q    <= {btn_c, btn_u, btn_d, btn_l, btn_r};
            btn_prev <= btn_q;
        end
    end

    // Next-state: placement, fire, resolve and cursor movement
    always_comb begin
        state_nxt = state;
        p1_nxt    = p1_board;
        p2_nxt    = p2_board;
        p1s_nxt   = p1_ships;
        p2s_nxt   = p2_ships;
        turn_nxt  = turn;
        cx_nxt    = cursor_x;
        cy_nxt    = cursor_y;
        win_nxt   = winner;
        cnt_nxt   = cnt;
        tgt_nxt   = tgt;
        move_en   = 1'b0;

        unique case (state)
            PLACE_P1, PLACE_P2: begin
                if (press[4]) begin
                    if (own_cell == EMPTY) begin
                        if (state == PLACE_P1)
                            p1_nxt[3*cur_idx +: 3] = SHIP;
                        else
                            p2_nxt[3*cur_idx +: 3] = SHIP;
                        if (cnt + 3'd1 == SHIPS) begin
                            state_nxt = (state == PLACE_P1) ?
                                        PLACE_P2 : FIRE;
                            turn_nxt  = ~turn;
                            cx_nxt    = 3'd0;
                            cy_nxt    = 3'd0;
                            cnt_nxt   = 3'd0;
                        end else begin
                            cnt_nxt = cnt + 3'd1;
                        end
                    end
                end else begin
                    move_en = 1'b1;
                end
            end
            FIRE: begin
                if (press[4]) begin
                    if (opp_cell == EMPTY || opp_cell == SHIP) begin
                        tgt_nxt   = cur_idx;
                        state_nxt = RESOLVE;
                    end
                end else begin
                    move_en = 1'b1;
                end
            end
            RESOLVE: begin
                if (res_cell == SHIP) begin
                    if (turn) begin
                        p1_nxt[3*tgt +: 3] = HIT;
                        p1s_nxt = ships_dec;
                    end else begin
                        p2_nxt[3*tgt +: 3] = HIT;
                        p2s_nxt = ships_dec;
                    end
                end else if (turn) begin
                    p1_nxt[3*tgt +: 3] = MISS;
                end else begin
                    p2_nxt[3*tgt +: 3] = MISS;
                end
                if (res_cell == SHIP && ships_dec == 3'd0) begin
                    state_nxt = GAME_OVER;
                    win_nxt   = turn;
                end else begin
                    state_nxt = FIRE;
                    turn_nxt  = ~turn;
                    cx_nxt    = 3'd0;
                    cy_nxt    = 3'd0;
                end
            end
            GAME_OVER: begin
                state_nxt = GAME_OVER;
            end
            default: begin
                state_nxt = PLACE_P1;
            end
        endcase

        if (move_en) begin
            priority case (1'b1)
                press[3]:
                    if (cursor_y != 3'd0) cy_nxt = cursor_y - 3'd1;
                press[2]:
                    if (cursor_y != Y_MAX) cy_nxt = cursor_y + 3'd1;
                press[1]:
                    if (cursor_x != 3'd0) cx_nxt = cursor_x - 3'd1;
                press[0]:
                    if (cursor_x != X_MAX) cx_nxt = cursor_x + 3'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_battleship_game_ctrl.sv
// Bench for battleship_game_ctrl: directed game plus random play,
// checked against a cell-array reference model.
module tb_battleship_game_ctrl;

    localparam int W = 5;
    localparam int H = 5;
    localparam int N = 5;
    localparam int BS = 3*W*H;

    localparam logic [4:0] BC = 5'b10000;
    localparam logic [4:0] BU = 5'b01000;
    localparam logic [4:0] BD = 5'b00100;
    localparam logic [4:0] BL = 5'b00010;
    localparam logic [4:0] BR = 5'b00001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_c = 0, btn_l = 0, btn_r = 0, btn_u = 0, btn_d = 0;
    logic [BS-1:0] p1_board, p2_board;
    logic [2:0] p1_ships, p2_ships, cursor_x, cursor_y, phase;
    logic turn, winner;

    int tests = 0;
    int fails = 0;

    int m_board[2][W*H];
    int m_ships[2];
    int m_turn, m_x, m_y, m_phase, m_win, m_cnt;

    always #5 clk = ~clk;

    battleship_game_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .btn_c(btn_c), .btn_l(btn_l), .btn_r(btn_r),
        .btn_u(btn_u), .btn_d(btn_d),
        .p1_board(p1_board), .p2_board(p2_board),
        .p1_ships(p1_ships), .p2_ships(p2_ships),
        .turn(turn), .cursor_x(cursor_x), .cursor_y(cursor_y),
        .phase(phase), .winner(winner)
    );

    task automatic chk(input string tag, input logic [BS-1:0] got,
                       input logic [BS-1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [BS-1:0] mvec(input int p);
        logic [BS-1:0] v;
        v = '0;
        for (int i = 0; i < W*H; i++) v[3*i +: 3] = 3'(m_board[p][i]);
        return v;
    endfunction

    task automatic check(input string t);
        chk({t, ".p1b"}, p1_board, mvec(0));
        chk({t, ".p2b"}, p2_board, mvec(1));
        chk({t, ".p1s"}, BS'(p1_ships), BS'(m_ships[0]));
        chk({t, ".p2s"}, BS'(p2_ships), BS'(m_ships[1]));
        chk({t, ".turn"}, BS'(turn), BS'(m_turn));
        chk({t, ".cx"}, BS'(cursor_x), BS'(m_x));
        chk({t, ".cy"}, BS'(cursor_y), BS'(m_y));
        chk({t, ".phase"}, BS'(phase), BS'(m_phase));
        chk({t, ".win"}, BS'(winner), BS'(m_win));
    endtask

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < W*H; i++) m_board[p][i] = 0;
            m_ships[p] = N;
        end
        m_turn = 0; m_x = 0; m_y = 0;
        m_phase = 0; m_win = 0; m_cnt = 0;
    endtask

    // Whole press effect, including the resolve step of a shot
    task automatic model_apply(input logic [4:0] m);
        int p, i;
        if (m_phase >= 3) return;
        i = m_y*W + m_x;
        if (m[4]) begin
            if (m_phase < 2) begin
                p = m_phase;
                if (m_board[p][i] == 0) begin
                    m_board[p][i] = 1;
                    m_cnt++;
                    if (m_cnt == N) begin
                        m_phase++; m_turn = 1 - m_turn;
                        m_x = 0; m_y = 0; m_cnt = 0;
                    end
                end
            end else begin
                p = 1 - m_turn;
                if (m_board[p][i] <= 1) begin
                    if (m_board[p][i] == 1) begin
                        m_board[p][i] = 3;
                        if (m_ships[p] > 0) m_ships[p]--;
                        if (m_ships[p] == 0) begin
                            m_phase = 4; m_win = m_turn;
                            return;
                        end
                    end else begin
                        m_board[p][i] = 2;
                    end
                    m_turn = 1 - m_turn; m_x = 0; m_y = 0;
                end
            end
        end else if (m[3]) begin
            if (m_y > 0) m_y--;
        end else if (m[2]) begin
            if (m_y < H-1) m_y++;
        end else if (m[1]) begin
            if (m_x > 0) m_x--;
        end else if (m[0]) begin
            if (m_x < W-1) m_x++;
        end
    endtask

    task automatic drive(input logic [4:0] m);
        {btn_c, btn_u, btn_d, btn_l, btn_r} = m;
    endtask

    task automatic press(input logic [4:0] m, input string t);
        @(negedge clk); drive(m);
        @(negedge clk);
        @(negedge clk); drive(5'b0);
        @(negedge clk);
        @(negedge clk);
        model_apply(m);
        check(t);
    endtask

    task automatic goto_xy(input int x, input int y);
        for (int k = 0; k < 8 && m_x < x; k++) press(BR, "goR");
        for (int k = 0; k < 8 && m_x > x; k++) press(BL, "goL");
        for (int k = 0; k < 8 && m_y < y; k++) press(BD, "goD");
        for (int k = 0; k < 8 && m_y > y; k++) press(BU, "goU");
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 0;
        @(negedge clk);
        @(negedge clk); rst_n = 1;
        model_reset();
    endtask

    task automatic place_all();
        for (int k = 0; k < N; k++) begin
            goto_xy(k, k);
            press(BC, "p1place");
        end
        for (int k = 0; k < N; k++) begin
            goto_xy(W-1-k, k);
            press(BC, "p2place");
        end
    endtask

    initial begin
        int p1x[4], p1y[4], p2x[3];
        logic [4:0] m;

        // Reset with btn_d held: no move until released and re-pressed
        btn_d = 1;
        do_reset();
        check("reset");
        repeat (3) @(negedge clk);
        check("held");
        btn_d = 0;
        repeat (3) @(negedge clk);
        check("release");
        press(BD, "d1");

        for (int k = 0; k < 3; k++) press(BR, "r3");
        for (int k = 0; k < 9; k++) press(BD, "d9");
        for (int k = 0; k < 5; k++) press(BR, "r5");
        chk("sat.x", BS'(cursor_x), BS'(4));
        chk("sat.y", BS'(cursor_y), BS'(4));

        goto_xy(2, 2);
        press(BU | BL, "u_l");
        chk("ul.y", BS'(cursor_y), BS'(1));
        press(BC | BR, "c_r");

        goto_xy(0, 0);
        press(BC, "c0a");
        press(BC, "c0b");
        goto_xy(1, 0); press(BC, "p1c");
        goto_xy(3, 3); press(BC, "p1d");
        goto_xy(4, 4); press(BC, "p1e");
        chk("p1done", BS'(phase), BS'(1));

        for (int k = 0; k < N; k++) begin
            goto_xy(k, k);
            press(BC, "p2place");
        end
        chk("p2done", BS'(phase), BS'(2));

        // Shot latency: RESOLVE one edge after sampling, update the next
        goto_xy(1, 1);
        @(negedge clk); btn_c = 1;
        @(posedge clk); #1;
        chk("lat.n0", BS'(phase), BS'(2));
        @(posedge clk); #1;
        chk("lat.n1", BS'(phase), BS'(3));
        chk("lat.n1c", BS'(p2_board[18 +: 3]), BS'(1));
        @(posedge clk); #1;
        chk("lat.n2c", BS'(p2_board[18 +: 3]), BS'(3));
        chk("lat.n2s", BS'(p2_ships), BS'(4));
        chk("lat.n2t", BS'(turn), BS'(1));
        @(negedge clk); btn_c = 0;
        @(negedge clk); @(negedge clk);
        model_apply(BC);
        check("hit1");

        goto_xy(4, 0); press(BC, "p2miss");
        goto_xy(1, 1); press(BC, "rehit");

        p1x = '{0, 2, 3, 4}; p1y = '{0, 2, 3, 4};
        p2x = '{0, 1, 2};
        for (int k = 0; k < 4; k++) begin
            goto_xy(p1x[k], p1y[k]); press(BC, "p1shot");
            if (k < 3) begin
                goto_xy(p2x[k], 4); press(BC, "p2shot");
            end
        end
        chk("go.phase", BS'(phase), BS'(4));
        chk("go.win", BS'(winner), BS'(0));
        chk("go.ships", BS'(p2_ships), BS'(0));
        press(BC, "go.c"); press(BU, "go.u");
        press(BR, "go.r"); press(BD | BC, "go.dc");

        // Reset landing on the RESOLVE cycle discards the shot
        do_reset();
        place_all();
        goto_xy(4, 0);
        @(negedge clk); btn_c = 1;
        @(posedge clk);
        @(posedge clk); #1;
        chk("mid.res", BS'(phase), BS'(3));
        @(negedge clk); rst_n = 0; btn_c = 0;
        @(posedge clk); #1;
        model_reset();
        check("midrst");
        @(negedge clk); rst_n = 1;

        // Random play against the model
        do_reset();
        for (int k = 0; k < 1500 && m_phase != 4; k++) begin
            m = {($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15))};
            press(m, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
